// File: rtl/m_cmp_pkg.sv
// m_cmp_pkg: shared types and helpers for the m_cmp_stream comparator.
// Frame FSM states, the per-lane flag triple and a width-agnostic
// greater-than used by the running-max tracker.
package m_cmp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic e;
    logic h;
    logic l;
  } flags_t;

  // Operands are extended to this width before cmp_max; WORD must be smaller.
  localparam int unsigned CMP_MAXW = 64;

  // a > b, two's-complement when s=1, unsigned when s=0.
  function automatic logic cmp_max(input logic [CMP_MAXW-1:0] a,
                                   input logic [CMP_MAXW-1:0] b,
                                   input logic                s);
    if (s) return $signed(a) > $signed(b);
    return a > b;
  endfunction

endpackage

// File: rtl/m_cmp_lane.sv
// m_cmp_lane: combinational compare of one operand pair into {e,h,l}.
// Signed interpretation exists only when M_CMP_SIGNED_EN is defined;
// otherwise i_sgn is ignored and the compare is unsigned.
module m_cmp_lane #(
  parameter int WORD = 8
) (
  input  logic [WORD-1:0] i_a,
  input  logic [WORD-1:0] i_b,
  input  logic            i_sgn,
  output logic            o_e,
  output logic            o_h,
  output logic            o_l
);

  logic w_gt;

`ifdef M_CMP_SIGNED_EN
  assign w_gt = i_sgn ? ($signed(i_a) > $signed(i_b)) : (i_a > i_b);
`else
  logic w_unused_sgn;
  assign w_unused_sgn = i_sgn;
  assign w_gt         = i_a > i_b;
`endif

  // Exactly one of the three flags is set for any operand pair.
  assign o_e = (i_a == i_b);
  assign o_h = w_gt;
  assign o_l = !w_gt && !o_e;

endmodule

// File: rtl/m_cmp_stream.sv
// m_cmp_stream: streaming CH-lane comparator with per-frame running max of A.
// Optional feature macro: M_CMP_SIGNED_EN (per-beat signed compare and
// frame-mode signed max tracking); when undefined everything is unsigned.
//
// Handshake: a beat transfers on a cycle where in_valid && in_ready;
// in_ready = !out_valid || out_ready, so the single output register is
// refilled in the same cycle it drains and holds its flags while stalled.
// out_valid/out_ready follow the same rule downstream. sum_valid is a bare
// one-cycle pulse with no ready.
module m_cmp_stream
  import m_cmp_pkg::*;
#(
  parameter int WORD = 8,
  parameter int CH   = 4,
  parameter int CNTW = 8,
  parameter int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*WORD-1:0]  A,
  input  logic [CH*WORD-1:0]  B,
  input  logic                sgn,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH-1:0]       E,
  output logic [CH-1:0]       H,
  output logic [CH-1:0]       L,
  output logic                out_last,
  output logic                sum_valid,
  output logic [WORD-1:0]     max_val,
  output logic [CHW-1:0]      max_ch,
  output logic [CNTW-1:0]     max_beat,
  output logic                beat_sat,
  output logic                o_dbg_state
);

  // Sign- or zero-extend one word for cmp_max.
  function automatic logic [CMP_MAXW-1:0] ext(input logic [WORD-1:0] v, input logic s);
    return {{(CMP_MAXW-WORD){s & v[WORD-1]}}, v};
  endfunction

  function automatic logic gt_word(input logic [WORD-1:0] a, input logic [WORD-1:0] b,
                                   input logic s);
    return cmp_max(ext(a, s), ext(b, s), s);
  endfunction

  state_t                r_state, w_state_nxt;
  logic                  r_out_valid, r_out_last, r_sum_valid, r_beat_sat;
  flags_t [CH-1:0]       r_flags, w_flags_nxt;
  logic [CH-1:0]         w_e, w_h, w_l;
  logic [WORD-1:0]       r_max_val, r_sh_val, w_nx_val, w_cand_val;
  logic [CHW-1:0]        r_max_ch, r_sh_ch, w_nx_ch, w_cand_ch;
  logic [CNTW-1:0]       r_max_beat, r_sh_beat, w_nx_beat, r_cnt, w_nx_cnt;
  logic                  r_sh_sat, w_nx_sat;
  logic                  w_accept, w_mode;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    m_cmp_lane #(.WORD(WORD)) u_lane (
      .i_a   (A[gi*WORD +: WORD]),
      .i_b   (B[gi*WORD +: WORD]),
      .i_sgn (sgn),
      .o_e   (w_e[gi]),
      .o_h   (w_h[gi]),
      .o_l   (w_l[gi])
    );
  end

`ifdef M_CMP_SIGNED_EN
  logic r_frame_sgn;

  // Latch the frame's compare mode from its first beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_frame_sgn <= 1'b0;
    else if (w_accept && r_state == ST_IDLE) r_frame_sgn <= sgn;
  end

  // The first beat uses its own sgn; later beats use the latched mode.
  assign w_mode = (r_state == ST_IDLE) ? sgn : r_frame_sgn;
`else
  assign w_mode = 1'b0;
`endif

  // Pack the lane flags and pick this beat's max-A lane (lowest lane on ties).
  always_comb begin
    w_flags_nxt = '0;
    w_cand_val  = A[WORD-1:0];
    w_cand_ch   = '0;
    for (int i = 0; i < CH; i++) begin
      w_flags_nxt[i] = '{e: w_e[i], h: w_h[i], l: w_l[i]};
    end
    for (int i = 1; i < CH; i++) begin
      if (gt_word(A[i*WORD +: WORD], w_cand_val, w_mode)) begin
        w_cand_val = A[i*WORD +: WORD];
        w_cand_ch  = CHW'(i);
      end
    end
  end

  // Frame FSM next state and shadow-tracker updates; only accepted beats move it.
  always_comb begin
    w_state_nxt = r_state;
    w_nx_val    = r_sh_val;
    w_nx_ch     = r_sh_ch;
    w_nx_beat   = r_sh_beat;
    w_nx_cnt    = r_cnt;
    w_nx_sat    = r_sh_sat;
    if (w_accept) begin
      w_state_nxt = in_last ? ST_IDLE : ST_RUN;
      case (r_state)
        ST_IDLE: begin
          w_nx_val  = w_cand_val;
          w_nx_ch   = w_cand_ch;
          w_nx_beat = '0;
          w_nx_cnt  = CNTW'(1);
          w_nx_sat  = 1'b0;
        end
        ST_RUN: begin
          // r_cnt is this beat's index, pinned at the saturated value.
          if (&r_cnt) w_nx_sat = 1'b1;
          else        w_nx_cnt = r_cnt + CNTW'(1);
          if (gt_word(w_cand_val, r_sh_val, w_mode)) begin
            w_nx_val  = w_cand_val;
            w_nx_ch   = w_cand_ch;
            w_nx_beat = r_cnt;
          end
        end
        default: ;
      endcase
    end
  end

  // State and shadow tracking registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_sh_val  <= '0;
      r_sh_ch   <= '0;
      r_sh_beat <= '0;
      r_cnt     <= '0;
      r_sh_sat  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sh_val  <= w_nx_val;
      r_sh_ch   <= w_nx_ch;
      r_sh_beat <= w_nx_beat;
      r_cnt     <= w_nx_cnt;
      r_sh_sat  <= w_nx_sat;
    end
  end

  // Flag output register with valid/ready hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_flags     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_last  <= in_last;
      r_flags     <= w_flags_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Publish the frame summary on the edge that takes the last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum_valid <= 1'b0;
      r_max_val   <= '0;
      r_max_ch    <= '0;
      r_max_beat  <= '0;
      r_beat_sat  <= 1'b0;
    end else if (w_accept && in_last) begin
      r_sum_valid <= 1'b1;
      r_max_val   <= w_nx_val;
      r_max_ch    <= w_nx_ch;
      r_max_beat  <= w_nx_beat;
      r_beat_sat  <= w_nx_sat;
    end else begin
      r_sum_valid <= 1'b0;
    end
  end

  // Unpack the registered flag structs onto the E/H/L buses.
  always_comb begin
    E = '0;
    H = '0;
    L = '0;
    for (int i = 0; i < CH; i++) begin
      E[i] = r_flags[i].e;
      H[i] = r_flags[i].h;
      L[i] = r_flags[i].l;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign sum_valid   = r_sum_valid;
  assign max_val     = r_max_val;
  assign max_ch      = r_max_ch;
  assign max_beat    = r_max_beat;
  assign beat_sat    = r_beat_sat;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_m_cmp_stream.sv
// tb_m_cmp_stream: directed and randomized bench for m_cmp_stream
// (WORD=8, CH=4, CNTW=2). A transaction-level model tracks flags and frame
// maxima with plain integer arithmetic; a negedge process compares every
// output each cycle, and directed sections pin literal expectations.
module tb_m_cmp_stream;

  localparam int WORD    = 8;
  localparam int CH      = 4;
  localparam int CNTW    = 2;
  localparam int CHW     = 2;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, in_valid, in_ready, sgn, in_last;
  logic [CH*WORD-1:0]  A, B;
  logic                out_valid, out_ready, out_last, sum_valid, beat_sat, dbg_state;
  logic [CH-1:0]       E, H, L;
  logic [WORD-1:0]     max_val;
  logic [CHW-1:0]      max_ch;
  logic [CNTW-1:0]     max_beat;

  m_cmp_stream #(.WORD(WORD), .CH(CH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sgn(sgn), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .E(E), .H(H), .L(L), .out_last(out_last), .sum_valid(sum_valid),
    .max_val(max_val), .max_ch(max_ch), .max_beat(max_beat),
    .beat_sat(beat_sat), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_ov, m_ol, m_sv, m_sat, f_open, f_sgn;
  logic [CH-1:0]   m_e, m_h, m_l;
  logic [WORD-1:0] m_mv;
  logic [CHW-1:0]  m_mc;
  logic [CNTW-1:0] m_mb;
  int              f_best, f_ch, f_beat, f_len;

  function automatic bit eff_sgn(input bit s);
`ifdef M_CMP_SIGNED_EN
    return s;
`else
    return 1'b0 & s;
`endif
  endfunction

  function automatic int lane_val(input logic [WORD-1:0] v, input bit s);
    int r;
    r = int'(v);
    if (s && v[WORD-1]) r = r - (1 << WORD);
    return r;
  endfunction

  task automatic model_reset();
    m_ov = 0; m_ol = 0; m_sv = 0; m_sat = 0; f_open = 0; f_sgn = 0;
    m_e = '0; m_h = '0; m_l = '0; m_mv = '0; m_mc = '0; m_mb = '0;
    f_best = 0; f_ch = 0; f_beat = 0; f_len = 0;
  endtask

  task automatic model_step();
    bit es;
    int a, b, v;
    if (!(in_valid && (!m_ov || out_ready))) begin
      m_sv = 0;
      if (out_ready) m_ov = 0;
      return;
    end
    es = eff_sgn(sgn);
    for (int i = 0; i < CH; i++) begin
      a = lane_val(A[i*WORD +: WORD], es);
      b = lane_val(B[i*WORD +: WORD], es);
      m_e[i] = (a == b);
      m_h[i] = (a > b);
      m_l[i] = (a < b);
    end
    m_ov = 1;
    m_ol = in_last;
    if (!f_open) begin
      f_open = 1; f_sgn = es; f_len = 0; f_best = -100000; f_ch = 0; f_beat = 0;
    end
    // Scan beats then lanes in arrival order; strict > keeps the earliest.
    for (int i = 0; i < CH; i++) begin
      v = lane_val(A[i*WORD +: WORD], f_sgn);
      if (v > f_best) begin
        f_best = v; f_ch = i; f_beat = f_len;
      end
    end
    f_len++;
    if (in_last) begin
      m_sv   = 1;
      m_mv   = WORD'(f_best);
      m_mc   = CHW'(f_ch);
      m_mb   = CNTW'((f_beat > CNT_MAX) ? CNT_MAX : f_beat);
      m_sat  = (f_len >= (1 << CNTW));
      f_open = 0;
    end else begin
      m_sv = 0;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",  in_ready,  (!m_ov || out_ready));
      chk("out_valid", out_valid, m_ov);
      chk("E",         E,         m_e);
      chk("H",         H,         m_h);
      chk("L",         L,         m_l);
      chk("out_last",  out_last,  m_ol);
      chk("sum_valid", sum_valid, m_sv);
      chk("max_val",   max_val,   m_mv);
      chk("max_ch",    max_ch,    m_mc);
      chk("max_beat",  max_beat,  m_mb);
      chk("beat_sat",  beat_sat,  m_sat);
      chk("dbg_state", dbg_state, f_open);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; the beat is taken at the next edge (out_ready=1).
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic last);
    in_valid = 1'b1; A = a; B = b; sgn = s; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  function automatic logic [WORD-1:0] rnd_byte();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h7f;
      2:       return 8'h80;
      3:       return 8'hff;
      default: return WORD'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; sgn = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #3 reset = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst E",         E,         0);
    chk("rst sum_valid", sum_valid, 0);
    chk("rst max_val",   max_val,   0);
    chk("rst dbg_state", dbg_state, 0);
    realign();
    reset = 1'b1;

    // Unsigned flags: lane3 0x80>0x01, lane2 5==5, lane1 5<9, lane0 0==0.
    send(32'h80050500, 32'h01050900, 1'b0, 1'b1);
    @(negedge clk);
    chk("uns E", E, 4'b0101);
    chk("uns H", H, 4'b1000);
    chk("uns L", L, 4'b0010);
    chk("uns out_valid", out_valid, 1);
    realign();

    // Lane 0: 0x80 vs 0x01 with sgn=1, then sgn=0.
    send(32'h00000080, 32'h00000001, 1'b1, 1'b1);
    @(negedge clk);
    chk("sgn1 E", E, 4'b1110);
`ifdef M_CMP_SIGNED_EN
    chk("sgn1 L", L, 4'b0001);
    chk("sgn1 H", H, 4'b0000);
`else
    chk("sgn1 L", L, 4'b0000);
    chk("sgn1 H", H, 4'b0001);
`endif
    realign();
    send(32'h00000080, 32'h00000001, 1'b0, 1'b1);
    @(negedge clk);
    chk("sgn0 H", H, 4'b0001);
    realign();

    // Backpressure: X held for 4 stalled cycles, Y offered the whole time.
    send(32'h05050505, 32'h05050505, 1'b0, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; A = 32'h09090909; B = 32'h05050505; in_last = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp in_ready", in_ready, 0);
      chk("bp E hold",   E,        4'b1111);
      realign();
    end
    out_ready = 1'b1;
    realign();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("bp Y H",       H,         4'b1111);
    chk("bp sum_valid", sum_valid, 1);
    chk("bp max_val",   max_val,   9);
    chk("bp max_beat",  max_beat,  1);
    realign();

    // Frame max: lane-0 A = 3, 9, 9.
    send(32'h00000003, '0, 1'b0, 1'b0);
    send(32'h00000009, '0, 1'b0, 1'b0);
    send(32'h00000009, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("fm sum_valid", sum_valid, 1);
    chk("fm max_val",   max_val,   9);
    chk("fm max_ch",    max_ch,    0);
    chk("fm max_beat",  max_beat,  1);
    chk("fm beat_sat",  beat_sat,  0);
    realign();
    chk("fm pulse end", sum_valid, 0);

    // Saturation: 6 beats, lane-0 A = 1..6, counter pinned at 3.
    for (int k = 1; k <= 6; k++) send(32'(k), '0, 1'b0, (k == 6));
    @(negedge clk);
    chk("sat max_val",  max_val,  6);
    chk("sat max_beat", max_beat, 3);
    chk("sat beat_sat", beat_sat, 1);
    realign();

    // Reset mid-frame, then a single-beat frame with 7 in lane 2.
    send(32'h00000011, '0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst out_valid", out_valid, 0);
    chk("mrst H",         H,         0);
    chk("mrst sum_valid", sum_valid, 0);
    chk("mrst max_val",   max_val,   0);
    chk("mrst beat_sat",  beat_sat,  0);
    realign();
    reset = 1'b1;
    send(32'h00070000, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("post sum_valid", sum_valid, 1);
    chk("post max_val",   max_val,   7);
    chk("post max_ch",    max_ch,    2);
    chk("post max_beat",  max_beat,  0);
    realign();

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 399) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sgn       = $urandom_range(0, 1);
      in_last   = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < CH; i++) begin
        A[i*WORD +: WORD] = rnd_byte();
        B[i*WORD +: WORD] = ($urandom_range(0, 3) == 0) ? A[i*WORD +: WORD] : rnd_byte();
      end
      realign();
    end

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) realign();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
